// File: rtl/trk_epoch_sequencer.sv
// Epoch sequencer for one tracking correlator: drop/release, arm, wait for ready,
// interrupt per epoch, clear between epochs, stop on count, command or timeout.
//
// state    | meaning
// IDLE     | waiting for START
// DROP     | drop_samples held high for DROP_CYCLES
// RELEASE  | one cycle with drop_samples low, still qualified
// ARM      | go pulse, restart ready detection and timeout
// WAIT_RDY | wait for ready rising edge after a 2-cycle mask
// SERVICE  | irq raised, waiting for software ack
// CLEAR    | clear_accum pulse, then one settle cycle
// STOP     | stop_tracking pulse, back to IDLE
module trk_epoch_sequencer #(
  parameter int DROP_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int CNT_W          = 16
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [CNT_W-1:0] i_num_epochs,
  input  logic             i_corr_ready,
  input  logic             i_irq_ack,
  output logic             o_drop_samples,
  output logic             o_drop_samples_valid,
  output logic             o_go,
  output logic             o_start_tracking_valid,
  output logic             o_clear_accum,
  output logic             o_stop_tracking,
  output logic             o_stop_tracking_valid,
  output logic             o_irq,
  output logic [CNT_W-1:0] o_epoch_count,
  output logic             o_busy,
  output logic             o_timeout,
  output logic [2:0]       o_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DROP    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_ARM     = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;
  localparam logic [2:0] ST_SERVICE = 3'd5;
  localparam logic [2:0] ST_CLEAR   = 3'd6;
  localparam logic [2:0] ST_STOP    = 3'd7;

  localparam int DW = $clog2(DROP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DROP_LOAD = DW'(DROP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state, state_nxt;
  logic [DW-1:0]    drop_cnt, drop_cnt_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic [1:0]       mask_cnt, mask_cnt_nxt;
  logic             clr_phase, clr_phase_nxt;
  logic             rdy_prev;
  logic [CNT_W-1:0] num_lat, num_lat_nxt;
  logic [CNT_W-1:0] epoch_cnt, epoch_cnt_nxt;
  logic             timeout_q, timeout_nxt;

  logic cmd_start, cmd_stop, rdy_edge, last_epoch;

  assign cmd_start  = i_cmd_valid && (i_cmd == 2'b01);
  assign cmd_stop   = i_cmd_valid && (i_cmd == 2'b11);
  assign rdy_edge   = (mask_cnt == 2'd2) && !rdy_prev && i_corr_ready;
  assign last_epoch = (num_lat != '0) && (epoch_cnt == num_lat);

  always_comb begin
    state_nxt     = state;
    drop_cnt_nxt  = drop_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    mask_cnt_nxt  = mask_cnt;
    clr_phase_nxt = 1'b0;
    num_lat_nxt   = num_lat;
    epoch_cnt_nxt = epoch_cnt;
    timeout_nxt   = timeout_q;

    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          state_nxt     = ST_DROP;
          drop_cnt_nxt  = DROP_LOAD;
          num_lat_nxt   = i_num_epochs;
          epoch_cnt_nxt = '0;
          timeout_nxt   = 1'b0;
        end
      end
      ST_DROP: begin
        if (drop_cnt == '0) state_nxt = ST_RELEASE;
        else                drop_cnt_nxt = drop_cnt - 1'b1;
      end
      ST_RELEASE: state_nxt = ST_ARM;
      ST_ARM: begin
        state_nxt    = ST_WAIT;
        tmo_cnt_nxt  = '0;
        mask_cnt_nxt = 2'd0;
      end
      ST_WAIT: begin
        tmo_cnt_nxt = tmo_cnt + 1'b1;
        if (mask_cnt != 2'd2) mask_cnt_nxt = mask_cnt + 2'd1;
        // a genuine ready edge wins over a coincident timeout
        if (rdy_edge) begin
          state_nxt     = ST_SERVICE;
          epoch_cnt_nxt = epoch_cnt + 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt   = ST_STOP;
          timeout_nxt = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (i_irq_ack) state_nxt = last_epoch ? ST_STOP : ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!clr_phase) clr_phase_nxt = 1'b1;
        else            state_nxt     = ST_ARM;
      end
      ST_STOP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // STOP overrides every other transition, so side effects of the lost transition are undone
    if (cmd_stop && (state != ST_STOP)) begin
      state_nxt     = ST_STOP;
      clr_phase_nxt = 1'b0;
      num_lat_nxt   = num_lat;
      epoch_cnt_nxt = epoch_cnt;
      timeout_nxt   = timeout_q;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state                  <= ST_IDLE;
      drop_cnt               <= '0;
      tmo_cnt                <= '0;
      mask_cnt               <= 2'd0;
      clr_phase              <= 1'b0;
      rdy_prev               <= 1'b0;
      num_lat                <= '0;
      epoch_cnt              <= '0;
      timeout_q              <= 1'b0;
      o_drop_samples         <= 1'b0;
      o_drop_samples_valid   <= 1'b0;
      o_go                   <= 1'b0;
      o_start_tracking_valid <= 1'b0;
      o_clear_accum          <= 1'b0;
      o_stop_tracking        <= 1'b0;
      o_stop_tracking_valid  <= 1'b0;
      o_irq                  <= 1'b0;
      o_busy                 <= 1'b0;
    end else begin
      state     <= state_nxt;
      drop_cnt  <= drop_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      mask_cnt  <= mask_cnt_nxt;
      clr_phase <= clr_phase_nxt;
      rdy_prev  <= (state == ST_ARM) ? 1'b0 : i_corr_ready;
      num_lat   <= num_lat_nxt;
      epoch_cnt <= epoch_cnt_nxt;
      timeout_q <= timeout_nxt;

      // outputs decoded from the next state so they line up with the state register
      o_drop_samples         <= (state_nxt == ST_DROP);
      o_drop_samples_valid   <= (state_nxt == ST_DROP) || (state_nxt == ST_RELEASE);
      o_go                   <= (state_nxt == ST_ARM);
      o_start_tracking_valid <= (state_nxt == ST_ARM);
      o_clear_accum          <= (state_nxt == ST_CLEAR) && !clr_phase_nxt;
      o_stop_tracking        <= (state_nxt == ST_STOP);
      o_stop_tracking_valid  <= (state_nxt == ST_STOP);
      o_irq                  <= (state_nxt == ST_SERVICE);
      o_busy                 <= (state_nxt != ST_IDLE);
    end
  end

  assign o_epoch_count = epoch_cnt;
  assign o_timeout     = timeout_q;
  assign o_state       = state;

endmodule

// File: tb/tb_trk_epoch_sequencer.sv
// Randomized bench for trk_epoch_sequencer; expected timings come from an
// epoch-level model of the ready/mask/timeout rules.
module tb_trk_epoch_sequencer;
  localparam int DROP_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CNT_W          = 16;

  logic             axis_aclk = 1'b0;
  logic             axis_aresetn = 1'b0;
  logic             i_cmd_valid = 1'b0;
  logic [1:0]       i_cmd = 2'b00;
  logic [CNT_W-1:0] i_num_epochs = '0;
  logic             i_corr_ready = 1'b0;
  logic             i_irq_ack = 1'b0;
  logic             o_drop_samples, o_drop_samples_valid, o_go, o_start_tracking_valid;
  logic             o_clear_accum, o_stop_tracking, o_stop_tracking_valid, o_irq;
  logic [CNT_W-1:0] o_epoch_count;
  logic             o_busy, o_timeout;
  logic [2:0]       o_state;

  trk_epoch_sequencer #(
    .DROP_CYCLES(DROP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .i_num_epochs(i_num_epochs),
    .i_corr_ready(i_corr_ready), .i_irq_ack(i_irq_ack),
    .o_drop_samples(o_drop_samples), .o_drop_samples_valid(o_drop_samples_valid),
    .o_go(o_go), .o_start_tracking_valid(o_start_tracking_valid),
    .o_clear_accum(o_clear_accum), .o_stop_tracking(o_stop_tracking),
    .o_stop_tracking_valid(o_stop_tracking_valid), .o_irq(o_irq),
    .o_epoch_count(o_epoch_count), .o_busy(o_busy), .o_timeout(o_timeout),
    .o_state(o_state)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int go_cnt = 0, clr_cnt = 0, stop_cnt = 0, qual_bad = 0;

  always @(negedge axis_aclk) begin
    if (axis_aresetn) begin
      go_cnt   = go_cnt + int'(o_go);
      clr_cnt  = clr_cnt + int'(o_clear_accum);
      stop_cnt = stop_cnt + int'(o_stop_tracking);
      if ((o_go != o_start_tracking_valid) || (o_stop_tracking != o_stop_tracking_valid))
        qual_bad = qual_bad + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge axis_aclk);
    #1;
  endtask

  function automatic int all_outs();
    return int'({o_drop_samples, o_drop_samples_valid, o_go, o_start_tracking_valid,
                 o_clear_accum, o_stop_tracking, o_stop_tracking_valid, o_irq,
                 o_epoch_count, o_busy, o_timeout, o_state});
  endfunction

  // Cycles from WAIT_RDY entry until it is left: first rising edge of the ready
  // sequence at index >= 2, else timeout; an earlier STOP command cuts it short.
  function automatic int exp_exit(input int r, input int dip, input int stop_idx);
    logic seq [0:TIMEOUT_CYCLES];
    int   ex;
    bit   found;
    ex = TIMEOUT_CYCLES;
    found = 1'b0;
    for (int k = 0; k <= TIMEOUT_CYCLES; k++) seq[k] = (k >= r) && (k != dip);
    for (int k = 2; k <= TIMEOUT_CYCLES - 2; k++)
      if (!found && !seq[k-1] && seq[k]) begin
        ex = k + 1;
        found = 1'b1;
      end
    if (stop_idx >= 0 && stop_idx + 1 <= ex) ex = stop_idx + 1;
    return ex;
  endfunction

  task automatic start_seq(input int n);
    int cnt;
    i_cmd_valid = 1'b1; i_cmd = 2'b01; i_num_epochs = CNT_W'(n);
    tick;
    i_cmd_valid = 1'b0; i_cmd = 2'b00; i_num_epochs = CNT_W'($urandom);
    check_eq("start_state", int'(o_state), 1);
    check_eq("start_count", int'(o_epoch_count), 0);
    check_eq("start_tmo", int'(o_timeout), 0);
    check_eq("start_busy", int'(o_busy), 1);
    cnt = 0;
    while (o_drop_samples && cnt < 64) begin
      cnt++;
      tick;
    end
    check_eq("drop_len", cnt, DROP_CYCLES);
    check_eq("release", int'({o_state, o_drop_samples, o_drop_samples_valid}), (2 << 2) | 1);
    tick;
    check_eq("arm_go", int'({o_state, o_go}), (3 << 1) | 1);
    tick;
    check_eq("wait_entry", int'(o_state), 4);
  endtask

  task automatic do_wait(input int r, input int dip, input int inj_idx,
                         input logic [1:0] inj_code, output int cyc);
    cyc = 0;
    while (o_state == 3'd4 && cyc < 400) begin
      i_corr_ready = (cyc >= r) && (cyc != dip);
      i_cmd_valid  = (cyc == inj_idx);
      i_cmd        = (cyc == inj_idx) ? inj_code : 2'b00;
      i_irq_ack    = (cyc == inj_idx) && (inj_code != 2'b11);
      i_num_epochs = CNT_W'($urandom);
      tick;
      cyc++;
    end
    i_cmd_valid = 1'b0; i_cmd = 2'b00; i_irq_ack = 1'b0;
  endtask

  // end_mode 0: stop on epoch count, 1: STOP command in WAIT after n_ep, 2: STOP with ack of epoch n_ep
  task automatic run_epochs(input int n, input int n_ep, input int end_mode, input bit fixed);
    int r, a, inj, cyc, g0, c0, s0, lost;
    logic [1:0] code;
    bit done, stop_now;
    g0 = go_cnt; c0 = clr_cnt; s0 = stop_cnt;
    done = 1'b0;
    start_seq(n);
    for (int e = 1; e <= n_ep; e++) begin
      if (!done) begin
        r    = fixed ? 49 : int'($urandom_range(2, 90));
        inj  = fixed ? -1 : int'($urandom_range(0, r));
        code = 2'($urandom_range(0, 2));
        do_wait(r, -1, inj, code, cyc);
        check_eq("wait_len", cyc, exp_exit(r, -1, -1));
        check_eq("svc_state", int'({o_state, o_irq}), (5 << 1) | 1);
        check_eq("svc_count", int'(o_epoch_count), e);
        a = fixed ? 3 : int'($urandom_range(0, 5));
        lost = 0;
        repeat (a) begin
          tick;
          if (!o_irq || o_state != 3'd5) lost++;
        end
        check_eq("irq_hold", lost, 0);
        stop_now = (end_mode == 2) && (e == n_ep);
        if (stop_now) begin i_cmd_valid = 1'b1; i_cmd = 2'b11; end
        i_irq_ack = 1'b1;
        tick;
        i_irq_ack = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'b00;
        if (stop_now || (n != 0 && e == n)) begin
          check_eq("stop_state", int'(o_state), 7);
          check_eq("stop_pulse", int'({o_stop_tracking, o_irq, o_clear_accum}), 4);
          check_eq("stop_count", int'(o_epoch_count), e);
          tick;
          check_eq("idle_after", int'({o_state, o_busy, o_stop_tracking}), 0);
          check_eq("idle_count", int'(o_epoch_count), e);
          done = 1'b1;
        end else begin
          check_eq("clr_pulse", int'({o_state, o_clear_accum, o_irq}), (6 << 2) | 2);
          tick;
          check_eq("clr_settle", int'({o_state, o_clear_accum}), 6 << 1);
          tick;
          check_eq("rearm_go", int'({o_state, o_go}), (3 << 1) | 1);
          tick;
          check_eq("rewait", int'(o_state), 4);
        end
      end
    end
    if (end_mode == 1) begin
      do_wait(1000, -1, 5, 2'b11, cyc);
      check_eq("cmd_stop_len", cyc, exp_exit(1000, -1, 5));
      check_eq("cmd_stop_st", int'({o_state, o_stop_tracking, o_irq}), (7 << 2) | 2);
      check_eq("cmd_stop_cnt", int'(o_epoch_count), n_ep);
      tick;
      check_eq("cmd_stop_idle", int'({o_state, o_irq}), 0);
    end
    check_eq("go_total", go_cnt - g0, (end_mode == 1) ? n_ep + 1 : n_ep);
    check_eq("clr_total", clr_cnt - c0, (end_mode == 1) ? n_ep : n_ep - 1);
    check_eq("stop_total", stop_cnt - s0, 1);
    check_eq("qualifiers", qual_bad, 0);
  endtask

  initial begin
    int cyc, n;
    #12;
    check_eq("rst_outs_low", all_outs(), 0);
    #11 axis_aresetn = 1'b1;
    tick;
    check_eq("rst_outs", all_outs(), 0);

    // NOP codes and an unqualified START are ignored
    i_cmd_valid = 1'b1; i_cmd = 2'b00; tick;
    i_cmd = 2'b10; tick;
    i_cmd_valid = 1'b0; i_cmd = 2'b01; tick;
    i_cmd = 2'b00;
    check_eq("nop_idle", int'({o_state, o_busy}), 0);

    // STOP from IDLE
    i_cmd_valid = 1'b1; i_cmd = 2'b11; tick;
    i_cmd_valid = 1'b0; i_cmd = 2'b00;
    check_eq("idle_stop", int'({o_state, o_stop_tracking, o_stop_tracking_valid, o_busy}),
             (7 << 3) | 7);
    tick;
    check_eq("idle_stop_back", int'({o_state, o_stop_tracking}), 0);

    run_epochs(2, 2, 0, 1'b1);
    run_epochs(0, 5, 1, 1'b0);

    // timeout with ready held low
    start_seq(1);
    do_wait(1000, -1, -1, 2'b00, cyc);
    check_eq("tmo_len", cyc, exp_exit(1000, -1, -1));
    check_eq("tmo_stop", int'({o_state, o_stop_tracking, o_timeout}), (7 << 2) | 3);
    tick;
    check_eq("tmo_idle_hold", int'({o_state, o_timeout}), 1);

    // ready rising inside the mask window is never seen: still a timeout
    start_seq(1);
    do_wait(1, -1, -1, 2'b00, cyc);
    check_eq("mask_len", cyc, exp_exit(1, -1, -1));
    check_eq("mask_tmo", int'({o_state, o_timeout}), (7 << 1) | 1);
    tick;

    // ready high through ARM: needs a drop and re-rise
    i_corr_ready = 1'b1;
    start_seq(2);
    do_wait(0, 20, -1, 2'b00, cyc);
    check_eq("held_len", cyc, exp_exit(0, 20, -1));
    check_eq("held_svc", int'(o_state), 5);
    i_cmd_valid = 1'b1; i_cmd = 2'b11; i_irq_ack = 1'b1; tick;
    i_cmd_valid = 1'b0; i_cmd = 2'b00; i_irq_ack = 1'b0;
    check_eq("held_stop", int'({o_state, o_clear_accum}), 7 << 1);
    tick;

    run_epochs(3, 1, 2, 1'b0);
    repeat (4) begin
      n = int'($urandom_range(1, 4));
      run_epochs(n, n, 0, 1'b0);
    end

    // async reset in the middle of DROP
    i_cmd_valid = 1'b1; i_cmd = 2'b01; i_num_epochs = 16'd3; tick;
    i_cmd_valid = 1'b0; i_cmd = 2'b00; tick;
    check_eq("pre_rst_drop", int'(o_state), 1);
    #2 axis_aresetn = 1'b0;
    #1 check_eq("rst_async", all_outs(), 0);
    #10 axis_aresetn = 1'b1;
    tick;
    check_eq("rst_idle", int'({o_state, o_busy}), 0);
    run_epochs(1, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
